// File: rtl/ttl_in_core.sv
// rtl/ttl_in_core.sv - TTL input edge timestamper with event FIFO
//
// Timestamps rising/falling edges on asynchronous TTL inputs against the
// shared 64-bit counter and queues one 128-bit event word per detection in a
// first-word-fall-through FIFO drained over a valid/ready handshake.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   counter[63:0]       timestamp source
//   input_pulse[N-1:0]  raw asynchronous TTL inputs
//   enable              capture events while high
//   rising_en           detect rising edges
//   falling_en          detect falling edges
//   flush               single-cycle FIFO and overflow clear
//   ts_dout[127:0]      head event word {counter, 32'b0, fmask, rmask}
//   ts_valid, ts_ready  head word handshake; pop on ts_valid & ts_ready
//   empty, full         FIFO occupancy flags
//   overflow_error      sticky, an event was dropped
//   overflow_count      dropped events, saturating
module ttl_in_core #(
    parameter int INPUT_NUM   = 8,
    parameter int DEPTH       = 16,
    parameter int ADDR_LEN    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          counter,
    input  logic [INPUT_NUM-1:0] input_pulse,
    input  logic                 enable,
    input  logic                 rising_en,
    input  logic                 falling_en,
    input  logic                 flush,
    output logic [127:0]         ts_dout,
    output logic                 ts_valid,
    input  logic                 ts_ready,
    output logic                 empty,
    output logic                 full,
    output logic                 overflow_error,
    output logic [15:0]          overflow_count
);

    logic [INPUT_NUM-1:0] sync_q [SYNC_STAGES];
    logic [INPUT_NUM-1:0] prev_q;
    logic [1:0]           warm_cnt;
    logic [ADDR_LEN:0]    wr_ptr;
    logic [ADDR_LEN:0]    rd_ptr;
    logic [127:0]         mem [DEPTH];

    logic [INPUT_NUM-1:0] sync_last;
    logic [15:0]          rmask16;
    logic [15:0]          fmask16;
    logic                 warm_done;
    logic                 event_det;
    logic                 pop;
    logic                 wr_req;
    logic                 wr_accept;
    logic                 drop;

    // Synchronizer chain and warm-up run regardless of enable/flush so that
    // levels present before capture is enabled never look like edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q   <= '0;
            warm_cnt <= 2'd0;
        end else begin
            sync_q[0] <= input_pulse;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
            if (warm_cnt != 2'd3) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign warm_done = (warm_cnt == 2'd3);

    always_comb begin
        rmask16 = '0;
        fmask16 = '0;
        rmask16[INPUT_NUM-1:0] = sync_last & ~prev_q & {INPUT_NUM{rising_en}};
        fmask16[INPUT_NUM-1:0] = ~sync_last & prev_q & {INPUT_NUM{falling_en}};
    end

    assign event_det = enable & warm_done & (|(rmask16 | fmask16));

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_LEN-1:0] == rd_ptr[ADDR_LEN-1:0]) &&
                      (wr_ptr[ADDR_LEN] != rd_ptr[ADDR_LEN]);
    assign ts_valid = ~empty;
    assign ts_dout  = mem[rd_ptr[ADDR_LEN-1:0]];

    // A pop in the same cycle frees the head slot, so a full FIFO can still
    // take a write; flush wins over everything and is never an overflow.
    assign pop       = ts_valid & ts_ready;
    assign wr_req    = event_det & ~flush;
    assign wr_accept = wr_req & (~full | pop);
    assign drop      = wr_req & full & ~pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            overflow_error <= 1'b0;
            overflow_count <= 16'd0;
        end else if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            overflow_error <= 1'b0;
            overflow_count <= 16'd0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + (ADDR_LEN+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (ADDR_LEN+1)'(1);
            end
            if (drop) begin
                overflow_error <= 1'b1;
                if (overflow_count != 16'hFFFF) begin
                    overflow_count <= overflow_count + 16'd1;
                end
            end
        end
    end

    // When full with a simultaneous pop the write lands in the slot being
    // vacated by the head, which is exactly the new tail position.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr[ADDR_LEN-1:0]] <= {counter, 32'd0, fmask16, rmask16};
        end
    end

endmodule

// File: tb/tb_ttl_in_core.sv
// tb/tb_ttl_in_core.sv - self-checking bench for ttl_in_core
module tb_ttl_in_core;

    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [63:0]  counter = 64'd0;
    logic [7:0]   input_pulse = 8'd0;
    logic         enable = 1'b0;
    logic         rising_en = 1'b0;
    logic         falling_en = 1'b0;
    logic         flush = 1'b0;
    logic [127:0] ts_dout;
    logic         ts_valid;
    logic         ts_ready = 1'b0;
    logic         empty;
    logic         full;
    logic         overflow_error;
    logic [15:0]  overflow_count;

    ttl_in_core #(
        .INPUT_NUM(8), .DEPTH(DEPTH), .ADDR_LEN(4), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .counter(counter), .input_pulse(input_pulse),
        .enable(enable), .rising_en(rising_en), .falling_en(falling_en),
        .flush(flush), .ts_dout(ts_dout), .ts_valid(ts_valid),
        .ts_ready(ts_ready), .empty(empty), .full(full),
        .overflow_error(overflow_error), .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: input history by clock edge, event queue, overflow.
    logic [127:0] m_q [$];
    bit           m_err;
    int           m_cnt;
    logic [7:0]   h1, h2, h3;   // input seen before edge k-1, k-2, k-3
    int           edges;        // edges since reset release

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_err = 0;
        m_cnt = 0;
        h1 = '0; h2 = '0; h3 = '0;
        edges = 0;
    endtask

    task automatic check_state();
        chk("empty", empty, m_q.size() == 0);
        chk("full", full, m_q.size() == DEPTH);
        chk("ts_valid", ts_valid, m_q.size() != 0);
        chk("overflow_error", overflow_error, m_err);
        chk("overflow_count", overflow_count, 16'(m_cnt));
        if (m_q.size() != 0) chk("ts_dout", ts_dout, m_q[0]);
    endtask

    // One clock: the model decides from the values present before the edge;
    // the sampled input becomes an edge two clocks later (two sync stages).
    task automatic tick();
        logic [7:0]   rm, fm;
        logic [127:0] w;
        bit           ev, pop, was_full;
        rm = rising_en  ? (h2 & ~h3) : 8'd0;
        fm = falling_en ? (~h2 & h3) : 8'd0;
        ev = enable && (edges >= 3) && ((rm | fm) != 8'd0);
        w = {counter, 32'd0, 8'd0, fm, 8'd0, rm};
        pop = ts_ready && (m_q.size() > 0);
        was_full = (m_q.size() == DEPTH);
        @(posedge clk);
        if (flush) begin
            m_q.delete();
            m_err = 0;
            m_cnt = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                if (!was_full || pop) m_q.push_back(w);
                else begin
                    m_err = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
        end
        h3 = h2; h2 = h1; h1 = input_pulse;
        if (edges < 3) edges++;
        #1;
        counter = counter + 64'd1;
        check_state();
    endtask

    task automatic do_reset(input logic [7:0] inp);
        @(posedge clk);
        #2;
        reset = 1'b1;
        input_pulse = inp;
        flush = 1'b0;
        #1;
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_valid", ts_valid, 1'b0);
        chk("rst_ovf_err", overflow_error, 1'b0);
        chk("rst_ovf_cnt", overflow_count, 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic drain();
        bit saved = ts_ready;
        repeat (3) tick();
        ts_ready = 1'b1;
        for (int i = 0; i < 40 && m_q.size() > 0; i++) tick();
        ts_ready = saved;
        chk("drain_empty", empty, 1'b1);
    endtask

    task automatic flip();
        logic [7:0] b;
        b = 8'd1 << $urandom_range(0, 7);
        input_pulse = input_pulse ^ b;
    endtask

    logic [63:0] t0;

    initial begin
        model_reset();
        enable = 1'b1; rising_en = 1'b1; falling_en = 1'b1;
        #20;

        // Level high at reset release must not produce an event.
        do_reset(8'h01);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("warmup_empty", empty, 1'b1);
        end

        // ch3 rises with counter=100 before E0 -> timestamp 102.
        counter = 64'd100;
        input_pulse = 8'h09;
        tick();
        tick();
        chk("ch3_not_yet", ts_valid, 1'b0);
        tick();
        chk("ch3_valid", ts_valid, 1'b1);
        chk("ch3_word", ts_dout, {64'd102, 32'd0, 16'h0000, 16'h0008});
        drain();

        // Simultaneous ch0 rise / ch5 fall, with and without falling_en.
        input_pulse = 8'h28;
        drain();
        input_pulse = 8'h09;
        repeat (3) tick();
        chk("multi_masks", ts_dout[31:0], 32'h0020_0001);
        drain();
        falling_en = 1'b0;
        input_pulse = 8'h28;
        repeat (3) tick();
        chk("rise_only", ts_dout[31:0], 32'h0000_0020);
        drain();
        falling_en = 1'b1;

        // 20 events with no consumer: 16 stored, 4 dropped.
        t0 = counter;
        for (int i = 0; i < 20; i++) begin
            flip();
            tick();
        end
        tick();
        tick();
        chk("ovf_full", full, 1'b1);
        chk("ovf_count4", overflow_count, 16'd4);
        chk("ovf_err", overflow_error, 1'b1);
        chk("ovf_first_ts", ts_dout[127:64], t0 + 64'd2);

        // Full FIFO, push and pop on the same edge.
        flip();
        tick();
        tick();
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
        chk("pushpop_full", full, 1'b1);
        chk("pushpop_count", overflow_count, 16'd4);
        drain();

        // Flush coincident with an event write while holding 5 words.
        for (int i = 0; i < 5; i++) begin
            flip();
            tick();
        end
        tick();
        tick();
        chk("hold5_valid", ts_valid, 1'b1);
        flip();
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_empty", empty, 1'b1);
        chk("flush_err", overflow_error, 1'b0);
        chk("flush_cnt", overflow_count, 16'd0);
        repeat (4) tick();
        chk("flush_no_word", empty, 1'b1);
        flip();
        repeat (3) tick();
        chk("after_flush_valid", ts_valid, 1'b1);
        drain();

        // Randomized traffic with a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset(8'($urandom));
            if ($urandom_range(0, 2) == 0) flip();
            enable     = ($urandom_range(0, 7) != 0);
            rising_en  = ($urandom_range(0, 3) != 0);
            falling_en = ($urandom_range(0, 3) != 0);
            ts_ready   = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 49) == 0);
            tick();
        end
        flush = 1'b0;
        enable = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ttl_in_core.md
# ttl_in_core

Input-side counterpart of the TTL output path: timestamps edges on external TTL inputs against the shared 64-bit TimeController `counter` and buffers one 128-bit event word per detection in an internal first-word-fall-through FIFO. Sits between the input pins and the AXI read path, which drains the FIFO over a valid/ready handshake. Inputs are asynchronous to `clk` and are synchronized inside the block.

## Interface
- `INPUT_NUM`, 8: number of TTL input channels, 1..16.
- `DEPTH`, 16: FIFO depth in words, power of two.
- `ADDR_LEN`, 4: log2(`DEPTH`).
- `SYNC_STAGES`, 2: synchronizer flops per input, at least 2.

Ports:
- `clk`  in  1  system clock; all logic is in this single domain.
- `reset`  in  1  asynchronous, active-high reset.
- `counter`  in  64  TimeController timestamp counter.
- `input_pulse`  in  INPUT_NUM  raw TTL inputs, asynchronous.
- `enable`  in  1  level; capture events while high.
- `rising_en`  in  1  level; detect rising edges.
- `falling_en`  in  1  level; detect falling edges.
- `flush`  in  1  single-cycle synchronous FIFO and error clear.
- `ts_dout`  out  128  head event word.
- `ts_valid`  out  1  head word valid (= not empty).
- `ts_ready`  in  1  consumer accepts the head word.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO holds `DEPTH` words.
- `overflow_error`  out  1  sticky; an event was dropped.
- `overflow_count`  out  16  number of dropped events, saturates at 16'hFFFF.

## Operation
- Synchronizer: `SYNC_STAGES` flops per channel, followed by one `prev` flop. rise = sync & ~prev; fall = ~sync & prev.
- Warm-up: a 2-bit counter holds detection off for 3 cycles after reset deassertion. During warm-up the sync and `prev` flops still shift, so a level that is already high at reset release does not produce an event.
- Event: rmask = rise & {INPUT_NUM{rising_en}}, fmask = fall & {INPUT_NUM{falling_en}}. An event is generated when `enable` is high, warm-up has finished, and (rmask | fmask) != 0.
- Gating does not stop the synchronizer chain. Raising `enable` while an input is high does not create an event.
- Word format:
  - [127:64] `counter` value registered on the detection cycle.
  - [63:32] zero.
  - [31:16] fmask, zero-extended.
  - [15:0] rmask, zero-extended.
- Edges on several channels in the same cycle produce one word with several mask bits set.
- FIFO: memory plus wr_ptr/rd_ptr of ADDR_LEN+1 bits each; pointer wrap uses the extra MSB.
  - `empty` = pointers equal.
  - `full` = addresses equal and MSBs differ.
  - `ts_dout` = mem[rd_ptr]; `ts_valid` = ~`empty`.
  - A pop occurs on `ts_valid` & `ts_ready`.
  - `ts_dout` is undefined while empty; the bench must not check it then.
- Write while full:
  - Without a simultaneous pop, the word is dropped, `overflow_error` sets, and `overflow_count` increments (saturating).
  - With a simultaneous pop, the write is accepted and occupancy stays at `DEPTH`.
- `flush`:
  - Resets both pointers to 0 and clears `overflow_error` and `overflow_count`.
  - An event in the same cycle is discarded and is not counted as an overflow.
  - The synchronizer, `prev` and warm-up state are not affected.
- `counter` wrap-around is not special-cased; the timestamp is the raw value.

## Timing
- Reset values: pointers 0, `empty`=1, `full`=0, `ts_valid`=0, `overflow_error`=0, `overflow_count`=0. Sync/`prev` flops are 0 and the warm-up counter is 0.
- Latency, with `SYNC_STAGES`=2, for an input transition settled before edge E0:
  - sync1 captures at E0 and sync2 at E1.
  - The edge is detected during the cycle after E1.
  - The word, timestamp included, is written at E2; the timestamp is the `counter` value present just before E2.
  - `ts_valid` is high after E2.
  - In general the write happens at edge E(SYNC_STAGES).
- Back-to-back events can be written on every cycle. Pops can occur every cycle; a push and a pop in the same cycle keep occupancy unchanged.
- `overflow_error` and `overflow_count` update at the edge of the dropped write.
- Reset asserted mid-operation clears everything asynchronously. Words in flight are lost, and warm-up restarts.

## Test plan
- Reset release with `input_pulse`=8'h01 held high, `enable`=1 -> no event; `empty` stays 1 for 20 cycles.
- `counter` increments by 1 per clock; ch3 rises when `counter`=100 at E0 -> one word at E2, [127:64]=102, [15:0]=16'h0008, [31:16]=0. `ts_valid` is high after E2.
- ch0 and ch5 toggle in the same cycle: ch0 rising, ch5 falling, `falling_en`=1 -> single word with rmask=16'h0001 and fmask=16'h0020. With `falling_en`=0 -> rmask only.
- `ts_ready`=0 and 20 single-channel events -> `full` after 16 words, `overflow_count`=4, `overflow_error`=1. Draining then returns the first 16 timestamps in order.
- FIFO full, a push and a pop in the same cycle -> push accepted, `full` stays 1, `overflow_count` unchanged.
- `flush` pulsed coincident with an event write while holding 5 words -> `empty`=1, `overflow_error`=0, `overflow_count`=0, and no word appears. The next edge is captured normally.
